// File: rtl/arq_pkg.sv
// Shared types and constants for the stop-and-wait ARQ transmitter.
// Holds the FSM state encoding, response polarity and the occupancy-width helper.
package arq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        DECIDE = 2'd3
    } arq_state_e;

    localparam logic RSP_NACK = 1'b0;
    localparam logic RSP_ACK  = 1'b1;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arq_fifo.sv
// Frame buffer for the ARQ transmitter: circular storage with occupancy,
// full flag and a sticky overflow flag. The head entry is read combinationally.
module arq_fifo
    import arq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]         head_data,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              accept;
    logic              do_pop;

    assign full   = (count_q == CNT_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
    assign accept = push && (!full || pop);
    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({accept, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/arq_tx_engine.sv
// Stop-and-wait ARQ transmitter: sends the FIFO head frame, waits for a matching
// ack, retransmits on nack/timeout and drops the frame after MAX_RETRY retries.
module arq_tx_engine
    import arq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int SEQ_W     = 2,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic [cnt_w(DEPTH)-1:0]       count,
    output logic                          overflow,
    output logic                          tx_valid,
    output logic [DATA_W-1:0]             tx_data,
    output logic [SEQ_W-1:0]              tx_seq,
    input  logic                          tx_ready,
    input  logic                          rsp_valid,
    input  logic                          rsp_ack,
    input  logic [SEQ_W-1:0]              rsp_seq,
    output logic                          done,
    output logic                          fail,
    output logic [cnt_w(MAX_RETRY)-1:0]   retry_cnt,
    output logic                          busy,
    output arq_state_e                    state_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RTY_W = cnt_w(MAX_RETRY);

    arq_state_e        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic              pop;
    logic              rsp_match;

    arq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .pop       (pop),
        .wr_data   (wr_data),
        .head_data (tx_data),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    // Link handshake: a frame transfers on a cycle where tx_valid && tx_ready;
    // tx_valid is held with data/seq stable until that cycle, then drops.
    // Responses with a sequence number other than the head's are stale.
    assign rsp_match = rsp_valid && (rsp_seq == seq_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            seq_q   <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            seq_q   <= seq_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        seq_d   = seq_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A matching response on the timeout cycle takes priority.
                if (rsp_match) begin
                    if (rsp_ack == RSP_ACK) begin
                        pop     = 1'b1;
                        done_d  = 1'b1;
                        seq_d   = seq_q + SEQ_W'(1);
                        retry_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = DECIDE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (retry_q == RTY_W'(MAX_RETRY)) begin
                    pop     = 1'b1;
                    fail_d  = 1'b1;
                    seq_d   = seq_q + SEQ_W'(1);
                    retry_d = '0;
                    state_d = IDLE;
                end else begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_valid  = (state_q == SEND);
    assign tx_seq    = seq_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign busy      = (state_q != IDLE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_arq_tx_engine.sv
// Scoreboarded bench for arq_tx_engine: expected link frames and done/fail
// events are queued by the stimulus and consumed by an independent monitor.
module tb_arq_tx_engine;
    import arq_pkg::*;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int SEQ_W     = 2;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = cnt_w(DEPTH);
    localparam int RTY_W     = cnt_w(MAX_RETRY);
    localparam logic [1:0] EV_DONE = 2'b01;
    localparam logic [1:0] EV_FAIL = 2'b10;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic [SEQ_W-1:0]  tx_seq;
    logic              tx_ready;
    logic              rsp_valid;
    logic              rsp_ack;
    logic [SEQ_W-1:0]  rsp_seq;
    logic              done;
    logic              fail;
    logic [RTY_W-1:0]  retry_cnt;
    logic              busy;
    arq_state_e        state;

    arq_tx_engine #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W),
        .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .count(count), .overflow(overflow),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_seq(tx_seq), .tx_ready(tx_ready),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_seq(rsp_seq),
        .done(done), .fail(fail), .retry_cnt(retry_cnt), .busy(busy), .state_o(state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [SEQ_W+DATA_W-1:0] exp_q[$];
    logic [1:0]              exp_ev_q[$];
    int unsigned             hs_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({tx_valid, tx_data, tx_seq, done, fail, retry_cnt, busy, full, count, overflow});
    endfunction

    // Monitor: every link handshake and every done/fail pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL tx_frame: unexpected frame seq=%0d data=0x%0h", tx_seq, tx_data);
                end else begin
                    check("tx_frame", 32'({tx_seq, tx_data}), 32'(exp_q.pop_front()));
                end
            end
            if (done || fail) begin
                if (exp_ev_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL event: unexpected done=%0b fail=%0b", done, fail);
                end else begin
                    check("event", 32'({fail, done}), 32'(exp_ev_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = d;
    endtask

    task automatic end_write();
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic expect_frame(input logic [SEQ_W-1:0] s, input logic [DATA_W-1:0] d);
        exp_q.push_back({s, d});
    endtask

    // Returns on the negedge just before a handshake edge.
    task automatic wait_hs();
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL hs_timeout: no handshake within 100 cycles (t=%0t)", $time);
        end
        hs_cyc = cyc;
    endtask

    task automatic respond(input logic ack, input logic [SEQ_W-1:0] s);
        @(posedge clk); #1;
        rsp_valid = 1'b1; rsp_ack = ack; rsp_seq = s;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] t1_data [4];
    int unsigned       prev_hs;

    initial begin
        t1_data[0] = 8'h00; t1_data[1] = 8'hA3; t1_data[2] = 8'h32; t1_data[3] = 8'h21;
        wr_en = 1'b0; wr_data = '0; tx_ready = 1'b0;
        rsp_valid = 1'b0; rsp_ack = 1'b0; rsp_seq = '0;
        do_reset();
        @(negedge clk);
        check("reset_outputs", all_outs(), 32'h0);

        // Test 1: four frames in order, each acked one cycle after the handshake
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_frame(SEQ_W'(k), t1_data[k]);
            exp_ev_q.push_back(EV_DONE);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) push_word(t1_data[k]);
                end_write();
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    wait_hs();
                    respond(RSP_ACK, SEQ_W'(k));
                end
            end
        join
        repeat (3) @(negedge clk);
        check("t1_count_empty", 32'(count), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Test 2: nack once then ack; seq has wrapped back to 0
        expect_frame(2'd0, 8'h5A);
        expect_frame(2'd0, 8'h5A);
        exp_ev_q.push_back(EV_DONE);
        push_word(8'h5A); end_write();
        wait_hs();
        respond(RSP_NACK, 2'd0);
        wait_hs();
        check("t2_retry_cnt", 32'(retry_cnt), 32'd1);
        respond(RSP_ACK, 2'd0);
        check("t2_retry_cleared", 32'(retry_cnt), 32'd0);
        expect_frame(2'd1, 8'h11);
        exp_ev_q.push_back(EV_DONE);
        push_word(8'h11); end_write();
        wait_hs();
        respond(RSP_ACK, 2'd1);
        repeat (3) @(negedge clk);

        // Test 3: no responses -> 4 sends spaced by the timeout, then fail
        do_reset();
        for (int k = 0; k < 4; k++) expect_frame(2'd0, 8'h77);
        exp_ev_q.push_back(EV_FAIL);
        push_word(8'h77); end_write();
        wait_hs();
        for (int k = 1; k < 4; k++) begin
            prev_hs = hs_cyc;
            wait_hs();
            check("t3_retx_spacing", 32'(hs_cyc - prev_hs), 32'(TIMEOUT + 2));
        end
        repeat (TIMEOUT + 6) @(negedge clk);
        check("t3_count_empty", 32'(count), 32'd0);
        check("t3_idle", 32'(busy), 32'd0);
        expect_frame(2'd1, 8'h78);
        exp_ev_q.push_back(EV_DONE);
        push_word(8'h78); end_write();
        wait_hs();
        respond(RSP_ACK, 2'd1);
        repeat (3) @(negedge clk);

        // Test 4: stale response is ignored, matching ack completes once
        do_reset();
        expect_frame(2'd0, 8'h4B);
        exp_ev_q.push_back(EV_DONE);
        push_word(8'h4B); end_write();
        wait_hs();
        respond(RSP_ACK, 2'd3);
        repeat (3) @(negedge clk);
        check("t4_still_waiting", 32'({busy, tx_valid}), 32'b10);
        respond(RSP_ACK, 2'd0);
        repeat (3) @(negedge clk);
        check("t4_idle", 32'(busy), 32'd0);

        // Test 5: fill with link stalled, 9th write overflows and is lost
        do_reset();
        tx_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            push_word(DATA_W'(8'h10 + k));
            expect_frame(SEQ_W'(k), DATA_W'(8'h10 + k));
            exp_ev_q.push_back(EV_DONE);
        end
        push_word(8'h99);
        end_write();
        @(negedge clk);
        check("t5_full", 32'(full), 32'd1);
        check("t5_count", 32'(count), 32'd8);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_head", 32'({tx_valid, tx_data}), 32'h110);
        @(posedge clk); #1 tx_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            wait_hs();
            respond(RSP_ACK, SEQ_W'(k));
        end
        repeat (3) @(negedge clk);
        check("t5_drained", 32'({full, count}), 32'd0);
        check("t5_overflow_sticky", 32'(overflow), 32'd1);

        // Test 6: asynchronous reset during WAIT with frames queued
        do_reset();
        tx_ready = 1'b0;
        push_word(8'h01); push_word(8'h02); push_word(8'h03); end_write();
        expect_frame(2'd0, 8'h01);
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_hs();
        @(posedge clk); #2 rst = 1'b1;
        #1 check("t6_async_reset", all_outs(), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        expect_frame(2'd0, 8'hC4);
        exp_ev_q.push_back(EV_DONE);
        push_word(8'hC4); end_write();
        wait_hs();
        respond(RSP_ACK, 2'd0);
        repeat (3) @(negedge clk);

        check("frames_pending", 32'(exp_q.size()), 32'd0);
        check("events_pending", 32'(exp_ev_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/arq_tx_engine.md
Name: arq_tx_engine

Overview:
Parametrised stop-and-wait ARQ transmitter. It is the successor to the 4-bit FIFO-with-ack/nack transmitter: it adds configurable data width and depth, sequence numbering, a response timeout and a bounded retry count. Frames are buffered in a FIFO and the head frame is sent. It is popped only on a matching ack, or when its retries are exhausted. It sits between the user write port and the link/channel model.

Parameters:
DATA_W, 8, payload width in bits
DEPTH, 8, FIFO entries (power of two, >=2)
SEQ_W, 2, sequence-number width; wraps modulo 2**SEQ_W
MAX_RETRY, 3, retransmissions allowed after the first send
TIMEOUT, 16, cycles in WAIT before an implicit nack (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  push wr_data into FIFO
wr_data  in  DATA_W  payload to enqueue
full  out  1  FIFO holds DEPTH entries
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky; set by wr_en while full and no pop in the same cycle
tx_valid  out  1  frame presented on link
tx_data  out  DATA_W  head payload
tx_seq  out  SEQ_W  sequence number of the head frame
tx_ready  in  1  link accepts the frame this cycle
rsp_valid  in  1  receiver response strobe
rsp_ack  in  1  1 = ack, 0 = nack (qualified by rsp_valid)
rsp_seq  in  SEQ_W  sequence number being acknowledged
done  out  1  one-cycle pulse: head frame acked and popped
fail  out  1  one-cycle pulse: head frame dropped after MAX_RETRY retries
retry_cnt  out  $clog2(MAX_RETRY+1)  retries spent on the current frame
busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: every output 0. Pointers, seq, timer and retry_cnt are 0. FSM is IDLE. overflow is cleared.
- FIFO:
  - Write accepted when wr_en && (!full || pop this cycle). A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - tx_data is the memory read at rd_ptr and is stable while busy.
- FSM states IDLE, SEND, WAIT, DECIDE:
  - IDLE:
    - If count>0, go to SEND next cycle.
    - Latency: a write into an empty FIFO gives tx_valid=1 two cycles after the wr_en edge.
  - SEND:
    - tx_valid=1.
    - When tx_ready=1, go to WAIT and set timer=0.
    - tx_valid deasserts the cycle after the handshake.
  - WAIT:
    - timer increments every cycle.
    - rsp_valid with rsp_seq==tx_seq: on ack, pop the head, pulse done, increment seq, clear retry_cnt and go to IDLE; on nack, go to DECIDE.
    - rsp_valid with a mismatched seq is ignored (stale response) and the timer keeps running.
    - timer==TIMEOUT-1 with no matching response is treated as a nack.
    - If a matching response arrives on the timeout cycle, the response wins.
  - DECIDE:
    - If retry_cnt==MAX_RETRY: pop the head, pulse fail, increment seq, clear retry_cnt and go to IDLE.
    - Otherwise increment retry_cnt and go to SEND (same payload, same seq).
- seq increments on both done and fail, so the receiver sees a fresh number for the next frame.
- Responses outside WAIT are ignored.
- wr_en is honoured in every state. Writes during WAIT/SEND never disturb the head entry.
- Reset mid-operation: immediate return to the reset state; in-flight and queued frames are discarded.

Decomposition:
- Package arq_pkg holds:
  - the FSM state enum (IDLE, SEND, WAIT, DECIDE);
  - a localparam helper for the count width;
  - the response encoding constants RSP_NACK=0, RSP_ACK=1.
- Sub-module arq_fifo holds storage, pointers, count, full and overflow, with ports push, pop, wr_data, head_data.
- The top module holds the FSM, timer, seq and retry counters.

Test Plan:
1. Reset, then write 0x00, 0xA3, 0x32, 0x21 on consecutive cycles (tx_ready=1) and ack each with matching seq 1 cycle after the handshake -> tx_data order 00,A3,32,21; tx_seq 0,1,2,3; four done pulses; count returns to 0; fail never asserts.
2. One frame 0x5A; nack it once, then ack -> two tx_valid handshakes both carrying 0x5A, seq 0; retry_cnt reads 1 before the ack; done pulses once; the next frame gets seq 1.
3. One frame 0x77 with no responses (TIMEOUT=16, MAX_RETRY=3) -> 4 sends spaced by the timeout; fail pulses once after the 4th timeout; seq advances to 1; count=0.
4. Response with rsp_seq=3 while waiting on seq 0, then a matching ack -> the stale response is ignored; exactly one done; no retransmission.
5. Fill DEPTH=8 entries with tx_ready=0, then write a 9th -> full=1, count=8, overflow=1; the 9th value never appears on tx_data.
6. Assert rst during WAIT with 3 entries queued -> all outputs 0 asynchronously; after release a new write 0xC4 is sent with tx_seq=0.
